dmem_mmio_responder: RTL and testbench

- Responder side of the core's data-memory interface.
- Accepts the address, write strobe and write data the core drives from its memory stage, and returns read data in the same cycle.
- Address-decodes into a word RAM plus a small memory-mapped peripheral block: LED register, free-running cycle counter and a programmable countdown timer.
- Sits beside the core at top level, replacing a plain data RAM.

---
 rtl/dmem_mmio_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM plus LED, cycle counter and countdown timer registers.
// Optional macro DMEM_MMIO_IRQ_EN adds the timer interrupt enable bit and the irq output.
module dmem_mmio_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LED_W     = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      dmem_addr,
  input  logic             dmem_write,
  input  logic [31:0]      dmem_write_data,
  output logic [31:0]      dmem_read_data,
  output logic [LED_W-1:0] leds
`ifdef DMEM_MMIO_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [13:0] OFF_LED    = 14'd0;
  localparam logic [13:0] OFF_CYCLE  = 14'd1;
  localparam logic [13:0] OFF_TLOAD  = 14'd2;
  localparam logic [13:0] OFF_TCTRL  = 14'd3;
  localparam logic [13:0] OFF_TCOUNT = 14'd4;

  logic [31:0]      ram_r [DEPTH];
  logic [LED_W-1:0] led_r;
  logic [31:0]      cycle_r;
  logic [31:0]      tload_r;
  logic [31:0]      tcount_r;
  logic             en_r;
  logic             auto_r;
  logic             done_r;
  logic             ie_r;
  logic             irq_r;

  logic             is_ram_s;
  logic             is_mmio_s;
  logic [AW-1:0]    ram_idx_s;
  logic [13:0]      off_s;
  logic             wr_mmio_s;
  logic             wr_led_s;
  logic             wr_tload_s;
  logic             wr_tctrl_s;
  logic             expire_s;
  logic [31:0]      tcount_nxt_s;
  logic             done_nxt_s;
  logic             ie_nxt_s;
  logic [31:0]      mmio_rd_s;
  logic             unused_s;

  // Byte-lane bits are ignored; RAM wins if the peripheral base ever aliases it.
  assign is_ram_s   = (dmem_addr[31:AW+2] == {(30-AW){1'b0}});
  assign is_mmio_s  = !is_ram_s && (dmem_addr[31:16] == MMIO_BASE[31:16]);
  assign ram_idx_s  = dmem_addr[AW+1:2];
  assign off_s      = dmem_addr[15:2];
  assign unused_s   = ^dmem_addr[1:0];

  assign wr_mmio_s  = dmem_write && is_mmio_s;
  assign wr_led_s   = wr_mmio_s && (off_s == OFF_LED);
  assign wr_tload_s = wr_mmio_s && (off_s == OFF_TLOAD);
  assign wr_tctrl_s = wr_mmio_s && (off_s == OFF_TCTRL);
  assign expire_s   = en_r && (tcount_r == 32'd1);

  // Timer next-state: a TLOAD write beats both decrement and reload, an expiry beats a DONE clear.
  always_comb begin
    tcount_nxt_s = tcount_r;
    done_nxt_s   = done_r;
    ie_nxt_s     = ie_r;
    if (wr_tload_s) begin
      tcount_nxt_s = dmem_write_data;
    end else if (expire_s) begin
      tcount_nxt_s = auto_r ? tload_r : 32'd0;
    end else if (en_r && (tcount_r != 32'd0)) begin
      tcount_nxt_s = tcount_r - 32'd1;
    end else begin
      tcount_nxt_s = tcount_r;
    end
    if (expire_s) begin
      done_nxt_s = 1'b1;
    end else if (wr_tctrl_s && dmem_write_data[2]) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
`ifdef DMEM_MMIO_IRQ_EN
    if (wr_tctrl_s) begin
      ie_nxt_s = dmem_write_data[3];
    end else begin
      ie_nxt_s = ie_r;
    end
`else
    ie_nxt_s = 1'b0;
`endif
  end

  // Peripheral register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r    <= {LED_W{1'b0}};
      cycle_r  <= 32'd0;
      tload_r  <= 32'd0;
      tcount_r <= 32'd0;
      en_r     <= 1'b0;
      auto_r   <= 1'b0;
      done_r   <= 1'b0;
      ie_r     <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      cycle_r  <= cycle_r + 32'd1;
      tcount_r <= tcount_nxt_s;
      done_r   <= done_nxt_s;
      ie_r     <= ie_nxt_s;
      irq_r    <= done_nxt_s & ie_nxt_s;
      if (wr_led_s) begin
        led_r <= dmem_write_data[LED_W-1:0];
      end
      if (wr_tload_s) begin
        tload_r <= dmem_write_data;
      end
      if (wr_tctrl_s) begin
        en_r   <= dmem_write_data[0];
        auto_r <= dmem_write_data[1];
      end
    end
  end

  // Word RAM; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (dmem_write && is_ram_s) begin
      ram_r[ram_idx_s] <= dmem_write_data;
    end
  end

  // Peripheral read mux.
  always_comb begin
    mmio_rd_s = 32'd0;
    case (off_s)
      OFF_LED:    mmio_rd_s = 32'(led_r);
      OFF_CYCLE:  mmio_rd_s = cycle_r;
      OFF_TLOAD:  mmio_rd_s = tload_r;
      OFF_TCTRL:  mmio_rd_s = {28'd0, ie_r, done_r, auto_r, en_r};
      OFF_TCOUNT: mmio_rd_s = tcount_r;
      default:    mmio_rd_s = 32'd0;
    endcase
  end

  // Region select for load data.
  always_comb begin
    dmem_read_data = 32'd0;
    if (is_ram_s) begin
      dmem_read_data = ram_r[ram_idx_s];
    end else if (is_mmio_s) begin
      dmem_read_data = mmio_rd_s;
    end else begin
      dmem_read_data = 32'd0;
    end
  end

  assign leds = led_r;
`ifdef DMEM_MMIO_IRQ_EN
  assign irq = irq_r;
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: directed plan steps then random traffic vs a register-level model.
module tb_dmem_mmio_responder;

  localparam logic [31:0] MB     = 32'hFFFF_0000;
  localparam logic [31:0] A_LED  = MB + 32'h00;
  localparam logic [31:0] A_CYC  = MB + 32'h04;
  localparam logic [31:0] A_TLD  = MB + 32'h08;
  localparam logic [31:0] A_TCT  = MB + 32'h0C;
  localparam logic [31:0] A_TCN  = MB + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dmem_addr = 32'd0;
  logic        dmem_write = 1'b0;
  logic [31:0] dmem_write_data = 32'd0;
  logic [31:0] dmem_read_data;
  logic [7:0]  leds;
  logic        irq;

  dmem_mmio_responder #(.DEPTH(256), .LED_W(8), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .dmem_addr(dmem_addr), .dmem_write(dmem_write),
    .dmem_write_data(dmem_write_data), .dmem_read_data(dmem_read_data), .leds(leds)
`ifdef DMEM_MMIO_IRQ_EN
    , .irq(irq)
`endif
  );
`ifndef DMEM_MMIO_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [7:0]  leds;
    logic        irq;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;

  // Reference model: architectural register values.
  logic [31:0] ram_m [int];
  logic [31:0] m_led, m_cycle, m_tload, m_tcount;
  bit          m_en, m_auto, m_done, m_ie;

  task automatic model_reset();
    m_led = 0; m_cycle = 0; m_tload = 0; m_tcount = 0;
    m_en = 0; m_auto = 0; m_done = 0; m_ie = 0;
  endtask

  function automatic bit ie_vis();
`ifdef DMEM_MMIO_IRQ_EN
    return m_ie;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    logic [31:0] off;
    if (a < 32'd1024) return ram_m.exists(int'(a >> 2)) ? ram_m[int'(a >> 2)] : 32'd0;
    if (a[31:16] != MB[31:16]) return 32'd0;
    off = {16'd0, a[15:0]} & 32'hFFFF_FFFC;
    case (off)
      32'h00: return m_led & 32'hFF;
      32'h04: return m_cycle;
      32'h08: return m_tload;
      32'h0C: return {28'd0, ie_vis(), m_done, m_auto, m_en};
      32'h10: return m_tcount;
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge: every rule evaluated against the state before the edge.
  task automatic model_edge(logic w, logic [31:0] a, logic [31:0] d);
    bit is_m, expired;
    logic [31:0] off, tc;
    is_m = (a >= 32'd1024) && (a[31:16] == MB[31:16]);
    off = {16'd0, a[15:0]} & 32'hFFFF_FFFC;
    expired = m_en && (m_tcount == 1);
    tc = m_tcount;
    if (m_en && m_tcount != 0) tc = m_tcount - 1;
    if (expired && m_auto) tc = m_tload;
    if (w && a < 32'd1024) ram_m[int'(a >> 2)] = d;
    if (w && is_m && off == 32'h00) m_led = d & 32'hFF;
    if (w && is_m && off == 32'h08) begin m_tload = d; tc = d; end
    if (w && is_m && off == 32'h0C) begin
      m_en = d[0]; m_auto = d[1]; m_ie = d[3];
      if (d[2]) m_done = 0;
    end
    if (expired) m_done = 1;
    m_tcount = tc;
    m_cycle = m_cycle + 1;
  endtask

  function automatic exp_t make_exp(string nm, logic [31:0] a);
    exp_t e;
    e.name = nm; e.rd = model_read(a); e.leds = m_led[7:0]; e.irq = m_done & ie_vis();
    return e;
  endfunction

  // Called just after a rising edge; presents one access for a whole cycle.
  task automatic drive(string nm, logic [31:0] a, logic w, logic [31:0] d);
    dmem_addr = a; dmem_write = w; dmem_write_data = d;
    exp_q.push_back(make_exp(nm, a));
    @(posedge clk); #1;
    model_edge(w, a, d);
    dmem_write = 1'b0;
  endtask

  task automatic rd(string nm, logic [31:0] a);
    drive(nm, a, 1'b0, 32'd0);
  endtask

  task automatic wr(string nm, logic [31:0] a, logic [31:0] d);
    drive(nm, a, 1'b1, d);
  endtask

  task automatic do_reset(string nm);
    reset = 1'b1; dmem_write = 1'b0; dmem_addr = A_TCT;
    model_reset();
    exp_q.push_back(make_exp(nm, A_TCT));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, ".rd"}, dmem_read_data, e.rd);
      chk({e.name, ".leds"}, {24'd0, leds}, {24'd0, e.leds});
`ifdef DMEM_MMIO_IRQ_EN
      chk({e.name, ".irq"}, {31'd0, irq}, {31'd0, e.irq});
`endif
    end
  end

  int unsigned k, idx;
  logic [31:0] ra, rdat;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    rd("cycle_after_reset", A_CYC);
    for (int i = 0; i < 9; i++) rd("cycle_idle", A_CYC);
    rd("cycle_ten", A_CYC);

    wr("ram_wr", 32'h40, 32'hDEAD_BEEF);
    rd("ram_rd", 32'h40);
    rd("ram_rd_lowbits", 32'h41);
    rd("ram_out_of_range", 32'h0000_8000);

    wr("led_wr", A_LED, 32'h1A5);
    rd("led_rd", A_LED);
    wr("cycle_wr_ignored", A_CYC, 32'h1234);
    rd("cycle_after_wr", A_CYC);

    force dut.cycle_r = 32'hFFFF_FFFE;
    #1 release dut.cycle_r;
    m_cycle = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) rd("cycle_wrap", A_CYC);

    wr("tload3", A_TLD, 32'd3);
    wr("tctrl_en", A_TCT, 32'h1);
    for (int i = 0; i < 5; i++) rd("tcount_down", A_TCN);
    rd("tctrl_done", A_TCT);
    wr("tctrl_clr", A_TCT, 32'h5);
    rd("tctrl_after_clr", A_TCT);

    wr("tctrl_off", A_TCT, 32'h0);
    wr("tload2", A_TLD, 32'd2);
    wr("tctrl_auto", A_TCT, 32'h3);
    for (int i = 0; i < 3; i++) rd("tcount_auto", A_TCN);
    wr("clr_on_expiry", A_TCT, 32'h7);
    rd("done_kept", A_TCT);
    rd("tcount_reload", A_TCN);

`ifdef DMEM_MMIO_IRQ_EN
    wr("ie_on", A_TCT, 32'hB);
    rd("irq_high", A_TCT);
    wr("irq_clr", A_TCT, 32'hC);
    rd("irq_low", A_TCT);
    wr("tload1", A_TLD, 32'd1);
    wr("ie_en", A_TCT, 32'h9);
    for (int i = 0; i < 3; i++) rd("irq_expire", A_TCT);
`endif

    wr("stop", A_TCT, 32'h0);
    wr("tload5", A_TLD, 32'd5);
    wr("start5", A_TCT, 32'h1);
    do_reset("reset_mid_count");
    rd("tcount_after_reset", A_TCN);
    rd("tload_after_reset", A_TLD);
    rd("ram_kept", 32'h40);

    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      ra = (idx << 2) | $urandom_range(0, 3);
      rdat = $urandom;
      case (k)
        0, 1: wr("rnd_ram_wr", ra, rdat);
        2: if (ram_m.exists(int'(ra >> 2))) rd("rnd_ram_rd", ra); else wr("rnd_ram_wr", ra, rdat);
        3: rd("rnd_mmio_rd", MB + ($urandom_range(0, 6) << 2) + $urandom_range(0, 3));
        4: wr("rnd_tload", A_TLD, $urandom_range(0, 6));
        5: wr("rnd_tctrl", A_TCT, {rdat[31:4], 4'(rdat[3:0])});
        6: wr("rnd_led", A_LED, rdat);
        7: drive("rnd_unmapped", {16'h1234, rdat[15:0]}, rdat[16], rdat);
        8: wr("rnd_mmio_wr", MB + ($urandom_range(0, 7) << 2), $urandom_range(0, 9));
        default: rd("rnd_tcount", A_TCN);
      endcase
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
